// File: rtl/rand_pkg.sv
// Shared definitions for the bounded random-draw block: FSM state encoding
// and standard maximal-length LFSR feedback masks.
package rand_pkg;

    // Draw FSM state encoding
    typedef logic [1:0] rand_state_t;

    localparam rand_state_t StIdle = 2'd0;
    localparam rand_state_t StDraw = 2'd1;
    localparam rand_state_t StHold = 2'd2;

    // Maximal-length feedback masks (bit i set: state[i] enters the XOR)
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h80200003;

endpackage

// File: rtl/lfsr_core.sv
// Free-running Fibonacci LFSR with seed load and lock-up recovery.
// Priority on each edge: rst > seed_we > lock-up recovery > step.
module lfsr_core
    import rand_pkg::*;
#(
    parameter int unsigned      WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(TAPS_16),
    parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_we,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic             fb;

    // Next-state: seed load (zero seed maps to default), lock-up escape, or shift
    always_comb begin
        fb = ^(state_q & TAPS);
        if (seed_we) begin
            state_d = (seed_in == '0) ? SEED_DEFAULT : seed_in;
        end else if (state_q == '0) begin
            state_d = SEED_DEFAULT;
        end else begin
            state_d = {state_q[WIDTH-2:0], fb};
        end
    end

    // LFSR register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED_DEFAULT;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/lfsr_rand_range.sv
// Bounded random draws in [0, range) from a free-running LFSR, using
// rejection sampling with a forced fallback after MAX_TRIES attempts.
// Optional build macro RAND_STATS_EN adds saturating draw/fallback counters.
module lfsr_rand_range
    import rand_pkg::*;
#(
    parameter int unsigned      WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(TAPS_16),
    parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1),
    parameter int unsigned      OUT_W        = 8,
    parameter int unsigned      MAX_TRIES    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_we,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    input  logic [OUT_W-1:0] range,
    output logic             req_ready,
    output logic             rand_valid,
    input  logic             rand_ready,
    output logic [OUT_W-1:0] rand_out,
    output logic             rand_err,
    output logic [WIDTH-1:0] lfsr_state
`ifdef RAND_STATS_EN
    ,
    output logic [15:0]      draw_count,
    output logic [15:0]      fallback_count
`endif
);

    localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    rand_state_t      state_q, state_d;
    logic [OUT_W-1:0] range_q, range_d;
    logic [TRY_W-1:0] try_q, try_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             err_q, err_d;
    logic [OUT_W-1:0] range_m1;
    logic [OUT_W-1:0] mask;
    logic [OUT_W-1:0] cand;
    logic             fallback;

    lfsr_core #(
        .WIDTH        (WIDTH),
        .TAPS         (TAPS),
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_lfsr_core (
        .clk     (clk),
        .rst     (rst),
        .seed_we (seed_we),
        .seed_in (seed_in),
        .state   (lfsr_state)
    );

    // Smallest all-ones mask covering range_q-1; candidate is the masked LFSR low bits
    always_comb begin
        range_m1 = range_q - OUT_W'(1);
        mask     = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            mask[i] = |(range_m1 >> i);
        end
        cand = lfsr_state[OUT_W-1:0] & mask;
    end

    // Draw FSM next-state and result capture
    always_comb begin
        state_d  = state_q;
        range_d  = range_q;
        try_d    = try_q;
        out_d    = out_q;
        err_d    = err_q;
        fallback = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    range_d = range;
                    try_d   = '0;
                    state_d = StDraw;
                end
            end
            StDraw: begin
                if (range_q == '0) begin
                    out_d   = '0;
                    err_d   = 1'b1;
                    state_d = StHold;
                end else if (cand < range_q) begin
                    out_d   = cand;
                    err_d   = 1'b0;
                    state_d = StHold;
                end else if (try_q == TRY_W'(MAX_TRIES - 1)) begin
                    // mask < 2*range_q, so one subtraction lands in range
                    out_d    = cand - range_q;
                    err_d    = 1'b0;
                    fallback = 1'b1;
                    state_d  = StHold;
                end else begin
                    try_d = try_q + TRY_W'(1);
                end
            end
            StHold: begin
                if (rand_ready) begin
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            range_q <= '0;
            try_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            range_q <= range_d;
            try_q   <= try_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign rand_valid = (state_q == StHold);
    assign rand_out   = out_q;
    assign rand_err   = err_q;

`ifdef RAND_STATS_EN
    logic [15:0] draw_cnt_q;
    logic [15:0] fb_cnt_q;

    // Saturating counters of completed handshakes and forced fallbacks
    always_ff @(posedge clk) begin
        if (rst) begin
            draw_cnt_q <= '0;
            fb_cnt_q   <= '0;
        end else begin
            if (rand_valid && rand_ready && (draw_cnt_q != 16'hFFFF)) begin
                draw_cnt_q <= draw_cnt_q + 16'd1;
            end
            if (fallback && (fb_cnt_q != 16'hFFFF)) begin
                fb_cnt_q <= fb_cnt_q + 16'd1;
            end
        end
    end

    assign draw_count     = draw_cnt_q;
    assign fallback_count = fb_cnt_q;
`endif

endmodule
